icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter SETS, default 16, number of direct-mapped one-word frames (power of 2).
REQ-002 SHALL have parameter IDX_W, default 4, index width, equal to log2(SETS).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imemREN  input  1  datapath instruction read request.
REQ-006 SHALL have port imemaddr  input  32  datapath instruction byte address (word-aligned).
REQ-007 SHALL have port ihit  output  1  instruction valid this cycle.
REQ-008 SHALL have port imemload  output  32  instruction word; meaningful only when ihit=1.
REQ-009 SHALL have port iREN  output  1  memory-side fill read request.
REQ-010 SHALL have port iaddr  output  32  memory-side fill address.
REQ-011 SHALL have port iwait  input  1  memory busy; iwait=0 while iREN=1 means iload valid this cycle.
REQ-012 SHALL have port iload  input  32  memory-side fill data.

Function
REQ-013 SHALL split address as tag=[31:IDX_W+2], index=[IDX_W+1:2], byte offset=[1:0]; offset ignored.
REQ-014 SHALL hold per frame: valid bit, tag, 32-bit data.
REQ-015 SHALL assert ihit combinationally, same cycle, iff imemREN=1, state=IDLE, frame[index].valid=1 and frame[index].tag equals address tag.
REQ-016 SHALL drive imemload = frame[index].data whenever ihit=1; 0 otherwise.
REQ-017 SHALL use FSM states IDLE and FETCH only.
REQ-018 IDLE->FETCH when imemREN=1 and lookup misses; latch imemaddr into miss-address register on that edge.
REQ-019 In FETCH SHALL drive iREN=1, iaddr=latched miss address, ihit=0; iREN=0 and iaddr=0 in IDLE.
REQ-020 FETCH->IDLE on the edge where iwait=0; same edge writes frame[latched index] with valid=1, latched tag, data=iload.
REQ-021 FETCH SHALL remain while iwait=1, with no cap on wait cycles.
REQ-022 Miss latency: hit on the refilled address SHALL occur the cycle after fill completes (1 + memory wait + 1 cycles minimum from miss).
REQ-023 If imemaddr changes or imemREN drops during FETCH (squash/halt), fill SHALL still complete to the latched address; new address looked up only after return to IDLE.
REQ-024 imemREN=0 in IDLE SHALL produce ihit=0 and no state change.
REQ-025 Conflict miss (same index, different tag) SHALL overwrite the frame; no write-back (read-only cache).
REQ-026 No other invalidation path; frames persist until reset.

Reset
REQ-027 nRST=0 SHALL asynchronously clear all valid bits, state=IDLE, miss-address=0.
REQ-028 During and immediately after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-029 Reset asserted mid-FETCH SHALL abort the fill with no frame written.

Structure
REQ-030 cpu_types_pkg SHALL hold word_t, an icache address struct (tag/idx/bytoff) and the icache FSM state enum.
REQ-031 Frame array, FSM and lookup SHALL live in icache; no sub-module.
REQ-032 Frame tag/data storage MAY be non-reset flops; only valid bits and FSM need reset.

Verification
REQ-033 After reset, imemREN=1, imemaddr=0x00000000 -> ihit=0, next cycle iREN=1, iaddr=0x0.
REQ-034 Memory returns iload=0x3C010001 with iwait=0 after 3 wait cycles -> next cycle ihit=1, imemload=0x3C010001, iREN=0.
REQ-035 Re-read 0x00000000 -> ihit=1 same cycle, no iREN; read 0x00000040 (same index, new tag) -> miss, fill overwrites, then 0x0 misses again.
REQ-036 During FETCH for 0x00000004 switch imemaddr to 0x00000008 -> iaddr stays 0x4 until iwait=0; 0x8 lookup begins next cycle.
REQ-037 Assert nRST=0 mid-FETCH -> iREN=0 immediately; after release, former miss address misses again.
REQ-038 Fill all 16 indices 0x00..0x3C, then read each -> 16 consecutive single-cycle hits.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types.
//   word_t          : 32-bit machine word
//   icachef_t       : instruction address split into tag / index / byte offset for the
//                     default 16-frame instruction cache
//   icache_state_t  : instruction cache controller states
package cpu_types_pkg;

   localparam int unsigned WORD_W       = 32;
   localparam int unsigned ICACHE_IDX_W = 4;
   localparam int unsigned ICACHE_TAG_W = WORD_W - ICACHE_IDX_W - 2;

   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      logic [ICACHE_TAG_W-1:0] tag;
      logic [ICACHE_IDX_W-1:0] idx;
      logic [1:0]              bytoff;
   } icachef_t;

   typedef enum logic {
      IDLE,
      FETCH
   } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Ports:
//   CLK, nRST          : clock (rising edge), asynchronous active-low reset
//   imemREN, imemaddr  : datapath instruction fetch request and byte address
//   ihit, imemload     : same-cycle hit indication and instruction word
//   iREN, iaddr        : memory-side fill request and address (held during FETCH)
//   iwait, iload       : memory busy flag and fill data (valid when iwait=0)
module icache
   import cpu_types_pkg::*;
#(
   parameter int unsigned SETS  = 16,
   parameter int unsigned IDX_W = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
);

   localparam int unsigned TAG_W = 32 - IDX_W - 2;

   icache_state_t state_q, state_d;
   word_t         miss_addr_q, miss_addr_d;

   logic [SETS-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [TAG_W-1:0] tag_d  [SETS];
   word_t            data_q [SETS];
   word_t            data_d [SETS];

   logic [IDX_W-1:0] req_idx, miss_idx;
   logic [TAG_W-1:0] req_tag, miss_tag;
   logic             lookup_hit;
   logic             fill_done;

   assign req_idx  = imemaddr[IDX_W+1:2];
   assign req_tag  = imemaddr[31:IDX_W+2];
   assign miss_idx = miss_addr_q[IDX_W+1:2];
   assign miss_tag = miss_addr_q[31:IDX_W+2];

   assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign fill_done  = (state_q == FETCH) && !iwait;

   // Lookup and memory-side outputs
   always_comb begin
      ihit     = 1'b0;
      imemload = '0;
      iREN     = 1'b0;
      iaddr    = '0;
      if (state_q == IDLE) begin
         ihit = imemREN && lookup_hit;
         if (ihit) imemload = data_q[req_idx];
      end else begin
         iREN  = 1'b1;
         iaddr = miss_addr_q;
      end
   end

   // Next state; the fill always targets the latched miss address, whatever the
   // datapath does to imemaddr/imemREN meanwhile.
   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      valid_d     = valid_q;
      tag_d       = tag_q;
      data_d      = data_q;
      unique case (state_q)
         IDLE: begin
            if (imemREN && !lookup_hit) begin
               state_d     = FETCH;
               miss_addr_d = imemaddr;
            end
         end
         FETCH: begin
            if (fill_done) begin
               state_d            = IDLE;
               valid_d[miss_idx]  = 1'b1;
               tag_d[miss_idx]    = miss_tag;
               data_d[miss_idx]   = iload;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state and valid bits; reset also aborts any fill in progress.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         miss_addr_q <= '0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         miss_addr_q <= miss_addr_d;
         valid_q     <= valid_d;
      end
   end

   // Tag/data storage needs no reset: valid bits gate every use.
   always_ff @(posedge CLK) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule
